// File: rtl/timer_programmable_if.sv
// Control/status bundle between a timer client (master) and timer_programmable (slave).
interface timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] end_at;
  logic [WIDTH-1:0] count;
  logic             timer_done;
  logic             busy;

  modport master (
    output en, start, stop, periodic, end_at,
    input  count, timer_done, busy
  );

  modport slave (
    input  en, start, stop, periodic, end_at,
    output count, timer_done, busy
  );
endinterface

// File: rtl/timer_programmable.sv
// Programmable interval timer: one-shot/periodic, start/stop/restart, single-cycle done pulse.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_programmable #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_END = 10,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] DEF_END = WIDTH'(DEFAULT_END);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic             per_q, per_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             tick;
  logic             expire;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = bus.en && (pre_q == PRE_LAST);

  // Prescaler restarts on any timing discontinuity so each period is whole.
  always_comb begin
    pre_d = pre_q;
    if (bus.stop || bus.start || expire || tick) begin
      pre_d = '0;
    end else if (bus.en) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = bus.en;

  // PRESCALE has no effect without the prescaler.
  if (PRESCALE == 0) begin : g_prescale_unused
  end
`endif

  assign expire = (state_q == RUN) && tick && (count_q == end_q - WIDTH'(1));

  // Next-state logic; priority is stop > start > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    end_d   = end_q;
    per_d   = per_q;
    done_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = '0;
      per_d   = bus.periodic;
      end_d   = (bus.end_at == '0) ? DEF_END : bus.end_at;
    end else if (expire) begin
      count_d = '0;
      done_d  = 1'b1;
      if (!per_q) begin
        state_d = IDLE;
      end
    end else if ((state_q == RUN) && tick) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      end_q   <= DEF_END;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      end_q   <= end_d;
      per_q   <= per_d;
      done_q  <= done_d;
      busy_q  <= (state_d == RUN);
    end
  end

  assign bus.count      = count_q;
  assign bus.timer_done = done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_timer_programmable.sv
// Directed self-checking bench for timer_programmable; prescaler case runs when TIMER_PRESCALE_EN is defined.
module tb_timer_programmable;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   failed;

  timer_if #(.WIDTH(WIDTH)) bus ();

  timer_programmable #(
    .WIDTH      (WIDTH),
    .DEFAULT_END(10),
    .PRESCALE   (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int c, input logic d, input logic b);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".done"}, 32'(bus.timer_done), 32'(d));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start is presented for one cycle; returns just after the start edge (edge 0).
  task automatic do_start(input int e, input logic per);
    bus.end_at   = WIDTH'(e);
    bus.periodic = per;
    bus.start    = 1'b1;
    cyc(1);
    bus.start    = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.periodic = 1'b0;
    bus.end_at   = '0;
    cyc(2);
    chk3("reset", 0, 1'b0, 1'b0);
    reset  = 1'b0;
    bus.en = 1'b1;
    cyc(2);
    chk3("idle_after_reset", 0, 1'b0, 1'b0);

`ifndef TIMER_PRESCALE_EN
    // One-shot, end_at=10: count 0..9, done after edge 10.
    do_start(10, 1'b0);
    chk3("os_start", 0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      chk3($sformatf("os_cnt%0d", i), i, 1'b0, 1'b1);
    end
    cyc(1);
    chk3("os_done", 0, 1'b1, 1'b0);
    cyc(1);
    chk3("os_after", 0, 1'b0, 1'b0);

    // Periodic, end_at=4: three periods, then stop on the 4th expiry edge.
    do_start(4, 1'b1);
    for (int p = 1; p <= 3; p++) begin
      cyc(3);
      chk3($sformatf("per%0d_pre", p), 3, 1'b0, 1'b1);
      cyc(1);
      chk3($sformatf("per%0d_done", p), 0, 1'b1, 1'b1);
    end
    cyc(3);
    chk3("per4_pre", 3, 1'b0, 1'b1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk3("per_stop", 0, 1'b0, 1'b0);

    // Pause at count 3 for 5 cycles: done delayed by exactly 5 clocks.
    do_start(10, 1'b0);
    cyc(3);
    chk3("pause_at3", 3, 1'b0, 1'b1);
    bus.en = 1'b0;
    cyc(5);
    chk3("paused", 3, 1'b0, 1'b1);
    bus.en = 1'b1;
    cyc(6);
    chk3("pause_cnt9", 9, 1'b0, 1'b1);
    cyc(1);
    chk3("pause_done", 0, 1'b1, 1'b0);

    // Restart at count 7 with end_at=3; end_at changes afterwards are ignored.
    do_start(10, 1'b0);
    cyc(7);
    chk3("rs_at7", 7, 1'b0, 1'b1);
    do_start(3, 1'b0);
    bus.end_at = WIDTH'(10);
    chk3("rs_start", 0, 1'b0, 1'b1);
    cyc(2);
    chk3("rs_cnt2", 2, 1'b0, 1'b1);
    cyc(1);
    chk3("rs_done", 0, 1'b1, 1'b0);
    cyc(3);
    chk3("rs_no_old", 0, 1'b0, 1'b0);

    // end_at=0 behaves as DEFAULT_END=10.
    do_start(0, 1'b0);
    cyc(9);
    chk3("def_cnt9", 9, 1'b0, 1'b1);
    cyc(1);
    chk3("def_done", 0, 1'b1, 1'b0);

    // end_at=1 periodic: done every cycle.
    do_start(1, 1'b1);
    chk3("one_start", 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk3($sformatf("one_done%0d", i), 0, 1'b1, 1'b1);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk3("one_stop", 0, 1'b0, 1'b0);

    // end_at=255: count reaches 254, done at edge 255.
    do_start(255, 1'b0);
    cyc(254);
    chk3("max_cnt254", 254, 1'b0, 1'b1);
    cyc(1);
    chk3("max_done", 0, 1'b1, 1'b0);

    // Async reset between edges at count 5.
    do_start(10, 1'b0);
    cyc(5);
    chk3("ar_at5", 5, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk3("ar_immediate", 0, 1'b0, 1'b0);
    cyc(1);
    reset = 1'b0;
    cyc(12);
    chk3("ar_stays_idle", 0, 1'b0, 1'b0);
    do_start(10, 1'b0);
    cyc(1);
    chk3("ar_resume", 1, 1'b0, 1'b1);
`else
    // PRESCALE=3, end_at=4: count steps every 3rd clock, done at edge 12.
    do_start(4, 1'b0);
    cyc(2);
    chk3("pre_e2", 0, 1'b0, 1'b1);
    cyc(1);
    chk3("pre_e3", 1, 1'b0, 1'b1);
    cyc(3);
    chk3("pre_e6", 2, 1'b0, 1'b1);
    cyc(5);
    chk3("pre_e11", 3, 1'b0, 1'b1);
    cyc(1);
    chk3("pre_done", 0, 1'b1, 1'b0);
    cyc(1);
    chk3("pre_after", 0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
